ak4619_tdm_responder: RTL and testbench
=======================================

AK4619_TDM_RESPONDER -- requirements
Module: ak4619_tdm_responder

Interface
REQ-001 The block SHALL expose parameter W, default 16, meaning sample width in bits (1..32).
REQ-002 The block SHALL expose parameter FRAME_CHECK, default 1, meaning lrck-misalignment detection is enabled when 1.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be as follows:
- clk_256fs  in  1  sole clock; bick/lrck/sdin1 are synchronous to it.
- rst  in  1  synchronous active-high reset.
- bick  in  1  TDM bit clock from the master; toggles at most once per clk_256fs cycle.
- lrck  in  1  TDM frame sync from the master.
- sdin1  in  1  serial DAC data from the master.
- sdout1  out  1  serial ADC data to the master.
- adc0..adc3  in  W each, signed  samples to transmit in slots 0..3.
- dac0..dac3  out  W each, signed  samples received in slots 0..3.
- dac_valid  out  1  one-cycle pulse when dac0..dac3 update.
- locked  out  1  frame alignment achieved.
- frame_err  out  1  one-cycle pulse on detected lrck misalignment.

Function
REQ-005 The frame SHALL be TDM128: 4 slots of 32 bits, MSB first, with each sample left-justified in bits 31..(32-W) of its slot and the remaining slot bits zero on sdout1 and ignored on sdin1.
REQ-006 A bick rising edge SHALL be detected in the cycle where bick=1 and its registered copy is 0; a falling edge SHALL be detected likewise with the values inverted.
REQ-007 On each bick rising edge the block SHALL sample sdin1 and lrck in that same cycle.
REQ-008 A bick rising edge with lrck=1 while the previous sampled lrck was 0 SHALL define bit 0 (slot 0 MSB) of a frame.
REQ-009 A 7-bit bit counter SHALL be reset to 0 at the frame-start edge and otherwise increment on each rising edge, wrapping 127->0.
REQ-010 The state machine SHALL have two states:
- UNLOCKED -> LOCKED on the first frame-start edge.
- LOCKED -> UNLOCKED on a misaligned frame start when FRAME_CHECK=1.
REQ-011 A misaligned frame start SHALL be a frame-start edge whose pre-increment counter value is not 127.
REQ-012 On a misaligned frame start the block SHALL pulse frame_err for one cycle and force the counter to 0.
REQ-013 On a misaligned frame start the block SHALL discard the partial DAC frame (no dac_valid) and SHALL NOT change state beyond REQ-010.
REQ-014 After REQ-013, the next correctly spaced frame start SHALL re-lock.
REQ-015 While UNLOCKED, sdout1 SHALL be 0 and dac_valid SHALL NOT pulse.
REQ-016 Received bits SHALL shift into a 32-bit deserialiser.
REQ-017 On the rising edge at counter 32k+31, slot k's top W bits SHALL be written to a holding register.
REQ-018 After the slot-3 write (counter 127), dac0..dac3 SHALL update together one cycle later, with dac_valid asserted in that same cycle.
REQ-019 adc0..adc3 SHALL be latched into a transmit buffer on the frame-start edge; mid-frame changes SHALL NOT affect the current frame.
REQ-020 sdout1 SHALL be registered and SHALL update in the cycle after each bick falling edge, presenting the bit for the next counter value so it is stable at the following rising edge.
REQ-021 The first bit (slot 0 MSB) SHALL be presented after the falling edge preceding the frame-start edge, using adc0 latched in the previous frame.
REQ-022 Consequently, ADC data SHALL be transmitted with a fixed latency of one frame.
REQ-023 Simultaneous rising edge and rst SHALL resolve to reset.
REQ-024 bick held static SHALL freeze all state; there is no timeout.

Reset
REQ-025 Reset SHALL drive sdout1=0, dac0..dac3=0, dac_valid=0, locked=0, frame_err=0.
REQ-026 Reset SHALL clear the counter, the holding and transmit buffers, and the edge-detect registers (bick copy=0, lrck copy=1 so that no false frame start occurs).
REQ-027 The state SHALL become UNLOCKED on reset.
REQ-028 Reset mid-frame SHALL abort the frame without dac_valid; operation SHALL resume at the next frame start.

Structure
REQ-029 Package ak4619_pkg SHALL hold SLOT_BITS=32, N_SLOTS=4, FRAME_BITS=128, and the lock-state enum {UNLOCKED, LOCKED}.
REQ-030 Sub-module bick_edge_detect SHALL register bick and emit rise/fall strobes; all other logic SHALL live in ak4619_tdm_responder.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- Loopback against ak4619 with W=16, bick=clk_256fs/2, adc0..3=16'h1234/16'hABCD/16'h8000/16'h7FFF -> master receives these values one frame later; master sends 16'h0F0F..16'hF0F0 -> dac0..3 match, with dac_valid once per 256 clk_256fs cycles.
- Reset for 10 cycles, then 3 frames -> locked rises at the first frame start; dac_valid first pulses at the end of frame 1; sdout1=0 before lock.
- lrck pulse injected at counter 60 -> frame_err pulses once, no dac_valid for that frame, locked=0, then re-lock and correct data on the following frame.
- adc0 changed 16'h1111->16'h2222 at counter 5 -> the current frame transmits the old latched value; 16'h2222 appears in the frame after the next frame start.
- rst asserted at counter 70 for 1 cycle -> all outputs zero; no dac_valid; normal data resumes after 2 frames.
- W=24: slot bits 7..0 on sdout1 are 0; dac0 receives the top 24 bits of slot 0 only.

Source files
------------

// File: rtl/ak4619_pkg.sv
// Shared constants and types for the AK4619 TDM128 responder.
// Frame geometry and the lock-state encoding live here so the top and its helpers agree.
package ak4619_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int N_SLOTS    = 4;
    localparam int FRAME_BITS = 128;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // True on the last bit position of a 32-bit slot.
    function automatic logic slot_end(input logic [4:0] pos);
        return (pos == 5'd31);
    endfunction

endpackage

// File: rtl/bick_edge_detect.sv
// Registers the oversampled bit clock and produces single-cycle rise/fall strobes.
// The registered copy clears to 0 so a bick already high after reset reads as a rise.
module bick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic bick,
    output logic rise,
    output logic fall
);

    logic bick_r;

    // Previous-cycle copy of bick.
    always_ff @(posedge clk) begin
        if (rst) begin
            bick_r <= 1'b0;
        end else begin
            bick_r <= bick;
        end
    end

    assign rise = bick & ~bick_r;
    assign fall = ~bick & bick_r;

endmodule

// File: rtl/ak4619_tdm_responder.sv
// TDM128 slave port for an AK4619 codec: deserialises four DAC slots from sdin1 and
// serialises four ADC samples onto sdout1, with lrck-based frame lock and misalignment check.
module ak4619_tdm_responder
    import ak4619_pkg::*;
#(
    parameter int W           = 16,
    parameter int FRAME_CHECK = 1
) (
    input  logic                clk_256fs,
    input  logic                rst,
    input  logic                bick,
    input  logic                lrck,
    input  logic                sdin1,
    output logic                sdout1,
    input  logic signed [W-1:0] adc0,
    input  logic signed [W-1:0] adc1,
    input  logic signed [W-1:0] adc2,
    input  logic signed [W-1:0] adc3,
    output logic signed [W-1:0] dac0,
    output logic signed [W-1:0] dac1,
    output logic signed [W-1:0] dac2,
    output logic signed [W-1:0] dac3,
    output logic                dac_valid,
    output logic                locked,
    output logic                frame_err
);

    localparam logic [5:0]       W6       = 6'(W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic              rise_s;
    logic              fall_s;
    logic              lrck_r;
    logic [CNT_W-1:0]  cnt_r;
    lock_state_e       state_r;
    lock_state_e       state_s;
    logic              frame_start_s;
    logic              misalign_s;
    logic              err_s;
    logic [CNT_W-1:0]  bit_idx_s;
    logic [CNT_W-1:0]  next_idx_s;
    logic [W-1:0]      deser_r;
    logic [W-1:0]      next_deser_s;
    logic [W-1:0]      hold_r    [N_SLOTS];
    logic [W-1:0]      tx_buf_r  [N_SLOTS];
    logic [W-1:0]      out_buf_r [N_SLOTS];
    logic [W-1:0]      dac_r     [N_SLOTS];
    logic [W-1:0]      tx_sel_s;
    logic [31:0]       tx_word_s;
    logic              tx_bit_s;
    logic              sdout_r;
    logic              dac_pend_r;
    logic              dac_valid_r;
    logic              frame_err_r;

    bick_edge_detect u_edge (
        .clk  (clk_256fs),
        .rst  (rst),
        .bick (bick),
        .rise (rise_s),
        .fall (fall_s)
    );

    assign frame_start_s = rise_s & lrck & ~lrck_r;
    assign misalign_s    = frame_start_s & (cnt_r != LAST_BIT);
    assign err_s         = misalign_s & (state_r == LOCKED) & (FRAME_CHECK != 0);
    // Index of the bit sampled on this rising edge; the outgoing bit is one ahead of cnt_r.
    assign bit_idx_s     = frame_start_s ? '0 : (cnt_r + 1'b1);
    assign next_idx_s    = cnt_r + 1'b1;

    // Only the first W bits of each slot are shifted in; the rest are ignored.
    always_comb begin
        next_deser_s = deser_r;
        if ({1'b0, bit_idx_s[4:0]} < W6) begin
            next_deser_s = (deser_r << 1) | W'(sdin1);
        end else begin
            next_deser_s = deser_r;
        end
    end

    // Slot 0 MSB comes straight from the freshly latched buffer, the rest from the frozen copy.
    always_comb begin
        tx_sel_s = '0;
        if (next_idx_s == '0) begin
            tx_sel_s = tx_buf_r[0];
        end else begin
            tx_sel_s = out_buf_r[next_idx_s[6:5]];
        end
    end

    assign tx_word_s = 32'(tx_sel_s) << (SLOT_BITS - W);
    assign tx_bit_s  = tx_word_s[5'd31 - next_idx_s[4:0]];

    // Lock state next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            UNLOCKED: begin
                if (frame_start_s) begin
                    state_s = LOCKED;
                end else begin
                    state_s = UNLOCKED;
                end
            end
            LOCKED: begin
                if (err_s) begin
                    state_s = UNLOCKED;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: state_s = UNLOCKED;
        endcase
    end

    // State, status pulses and receive-side registers.
    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            state_r     <= UNLOCKED;
            lrck_r      <= 1'b1;
            cnt_r       <= '0;
            deser_r     <= '0;
            dac_pend_r  <= 1'b0;
            dac_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            for (int k = 0; k < N_SLOTS; k++) begin
                hold_r[k] <= '0;
                dac_r[k]  <= '0;
            end
        end else begin
            state_r     <= state_s;
            frame_err_r <= err_s;
            dac_pend_r  <= rise_s & (state_r == LOCKED) & (bit_idx_s == LAST_BIT);
            dac_valid_r <= dac_pend_r;
            if (dac_pend_r) begin
                for (int k = 0; k < N_SLOTS; k++) begin
                    dac_r[k] <= hold_r[k];
                end
            end
            if (rise_s) begin
                lrck_r  <= lrck;
                cnt_r   <= bit_idx_s;
                deser_r <= next_deser_s;
                if (slot_end(bit_idx_s[4:0])) begin
                    hold_r[bit_idx_s[6:5]] <= next_deser_s;
                end
            end
        end
    end

    // Transmit side: latch at frame start, freeze for the next frame, shift out after each fall.
    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            sdout_r <= 1'b0;
            for (int k = 0; k < N_SLOTS; k++) begin
                tx_buf_r[k]  <= '0;
                out_buf_r[k] <= '0;
            end
        end else begin
            if (frame_start_s) begin
                tx_buf_r[0] <= adc0;
                tx_buf_r[1] <= adc1;
                tx_buf_r[2] <= adc2;
                tx_buf_r[3] <= adc3;
            end
            if (fall_s && (cnt_r == LAST_BIT)) begin
                for (int k = 0; k < N_SLOTS; k++) begin
                    out_buf_r[k] <= tx_buf_r[k];
                end
            end
            if (state_s == UNLOCKED) begin
                sdout_r <= 1'b0;
            end else if (fall_s) begin
                sdout_r <= tx_bit_s;
            end
        end
    end

    assign sdout1    = sdout_r;
    assign dac0      = dac_r[0];
    assign dac1      = dac_r[1];
    assign dac2      = dac_r[2];
    assign dac3      = dac_r[3];
    assign dac_valid = dac_valid_r;
    assign frame_err = frame_err_r;
    assign locked    = (state_r == LOCKED);

endmodule

// File: tb/tb_ak4619_tdm_responder.sv
// Directed bench: a TDM128 master model drives a W=16 and a W=24 responder side by side.
module tb_ak4619_tdm_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, bick, lrck, sdin1;
    logic signed [15:0] a16 [4];
    logic signed [23:0] a24 [4];
    logic signed [15:0] d16 [4];
    logic signed [23:0] d24 [4];
    logic sdo16, sdo24, dv16, dv24, lk16, lk24, fe16, fe24;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int dv24_cnt = 0;
    int fe_cnt = 0;
    int dv_t[$];

    ak4619_tdm_responder #(.W(16), .FRAME_CHECK(1)) dut16 (
        .clk_256fs(clk), .rst(rst), .bick(bick), .lrck(lrck), .sdin1(sdin1), .sdout1(sdo16),
        .adc0(a16[0]), .adc1(a16[1]), .adc2(a16[2]), .adc3(a16[3]),
        .dac0(d16[0]), .dac1(d16[1]), .dac2(d16[2]), .dac3(d16[3]),
        .dac_valid(dv16), .locked(lk16), .frame_err(fe16)
    );

    ak4619_tdm_responder #(.W(24), .FRAME_CHECK(1)) dut24 (
        .clk_256fs(clk), .rst(rst), .bick(bick), .lrck(lrck), .sdin1(sdin1), .sdout1(sdo24),
        .adc0(a24[0]), .adc1(a24[1]), .adc2(a24[2]), .adc3(a24[3]),
        .dac0(d24[0]), .dac1(d24[1]), .dac2(d24[2]), .dac3(d24[3]),
        .dac_valid(dv24), .locked(lk24), .frame_err(fe24)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (dv16) begin
            dv_cnt <= dv_cnt + 1;
            dv_t.push_back(cyc);
        end
        if (dv24) dv24_cnt <= dv24_cnt + 1;
        if (fe16) fe_cnt <= fe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One 128-bit master frame: bick = clk/2, lrck high on bit 0 and optionally on bit inj.
    task automatic run_frame(input logic [127:0] tx, input int inj, input int chg, input int rst_at,
                             output logic [127:0] rx16, output logic [127:0] rx24, output logic lk0);
        rx16 = '0;
        rx24 = '0;
        lk0  = 1'b0;
        for (int i = 0; i < 128; i++) begin
            if (i == rst_at) begin
                @(negedge clk) rst = 1'b1;
                @(negedge clk) rst = 1'b0;
            end
            if (i == chg) a16[0] = 16'sh2222;
            @(negedge clk);
            bick  = 1'b0;
            lrck  = (i == 0) || (i == inj);
            sdin1 = tx[127-i];
            @(negedge clk);
            rx16[127-i] = sdo16;
            rx24[127-i] = sdo24;
            bick = 1'b1;
            if (i == 0) begin
                @(posedge clk);
                #1 lk0 = lk16;
            end
        end
    endtask

    localparam logic [127:0] TX_A  = 128'h0F0FA5C3_3C3C5A96_C3C31234_F0F08001;
    localparam logic [127:0] TX_B  = 128'h5555FFFF_AAAA0000_0001FFFF_FFFE0001;
    localparam logic [63:0]  A16   = 64'h0F0F_3C3C_C3C3_F0F0;
    localparam logic [95:0]  A24   = 96'h0F0FA5_3C3C5A_C3C312_F0F080;
    localparam logic [63:0]  B16   = 64'h5555_AAAA_0001_FFFE;
    localparam logic [95:0]  B24   = 96'h5555FF_AAAA00_0001FF_FFFE00;
    localparam logic [127:0] RX16  = 128'h12340000_ABCD0000_80000000_7FFF0000;
    localparam logic [127:0] RX24  = 128'h12345600_ABCDEF00_80000000_7FFFFF00;
    localparam logic [127:0] RX16C = 128'h22220000_ABCD0000_80000000_7FFF0000;

    initial begin
        logic [127:0] r16, r24;
        logic lk;
        int per;
        rst = 1'b1; bick = 1'b0; lrck = 1'b0; sdin1 = 1'b0;
        a16[0] = 16'sh1234; a16[1] = -16'sh5433; a16[2] = -16'sh8000; a16[3] = 16'sh7FFF;
        a24[0] = 24'sh123456; a24[1] = -24'sh543211; a24[2] = -24'sh800000; a24[3] = 24'sh7FFFFF;

        repeat (10) @(negedge clk);
        chk("rst_outs16", {sdo16, dv16, lk16, fe16}, 4'b0000);
        chk("rst_dac16", {d16[0], d16[1], d16[2], d16[3]}, 64'h0);
        chk("rst_outs24", {sdo24, dv24, lk24, fe24}, 4'b0000);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk) bick = 1'b0;
            @(negedge clk);
            chk("prelock_sdout", {sdo16, sdo24}, 2'b00);
            bick = 1'b1;
        end
        chk("prelock_locked", lk16, 1'b0);

        run_frame(TX_A, -1, -1, -1, r16, r24, lk);              // F1
        chk("lock_at_start", lk, 1'b1);
        chk("f1_rx16_zero", r16, 128'h0);
        run_frame(TX_A, -1, -1, -1, r16, r24, lk);              // F2
        chk("dv_after_f1", dv_cnt, 1);
        chk("dac16_a", {d16[0], d16[1], d16[2], d16[3]}, A16);
        chk("dac24_a", {d24[0], d24[1], d24[2], d24[3]}, A24);
        chk("f2_rx16", r16, RX16);
        chk("f2_rx24", r24, RX24);
        a16[0] = 16'sh1111;
        run_frame(TX_A, -1, -1, -1, r16, r24, lk);              // F3
        per = (dv_t.size() >= 2) ? (dv_t[1] - dv_t[0]) : -1;
        chk("dv_period", 32'(per), 32'd256);
        chk("f3_rx16", r16, RX16);
        run_frame(TX_A, -1, 5, -1, r16, r24, lk);               // F4, adc0 -> 2222 at bit 5
        chk("f4_slot0", r16[127:112], 16'h1111);
        run_frame(TX_A, -1, -1, -1, r16, r24, lk);              // F5
        chk("f5_slot0", r16[127:112], 16'h1111);
        run_frame(TX_A, -1, -1, -1, r16, r24, lk);              // F6
        chk("f6_rx16", r16, RX16C);
        chk("dv_after_f5", dv_cnt, 5);
        chk("dv24_match", dv24_cnt, dv_cnt);

        run_frame(TX_B, 60, -1, -1, r16, r24, lk);              // F7, stray lrck at bit 60
        chk("inj_frame_err", fe_cnt, 1);
        chk("inj_unlocked", lk16, 1'b0);
        chk("inj_sdout_zero", r16[67:0], 68'h0);
        run_frame(TX_B, -1, -1, -1, r16, r24, lk);              // F8
        chk("relock", lk, 1'b1);
        chk("inj_no_dv", dv_cnt, 6);
        chk("relock_no_err", fe_cnt, 1);
        run_frame(TX_A, -1, -1, -1, r16, r24, lk);              // F9
        chk("dv_after_f8", dv_cnt, 7);
        chk("dac16_b", {d16[0], d16[1], d16[2], d16[3]}, B16);
        chk("dac24_b", {d24[0], d24[1], d24[2], d24[3]}, B24);

        run_frame(TX_A, -1, -1, 70, r16, r24, lk);              // F10, rst at bit 70
        chk("rst_mid_dac", {d16[0], d16[1], d16[2], d16[3]}, 64'h0);
        chk("rst_mid_outs", {lk16, fe16, dv16, sdo16}, 4'b0000);
        run_frame(TX_B, -1, -1, -1, r16, r24, lk);              // F11
        chk("rst_relock", lk, 1'b1);
        chk("rst_no_dv", dv_cnt, 8);
        chk("f11_rx16_zero", r16, 128'h0);
        run_frame(TX_A, -1, -1, -1, r16, r24, lk);              // F12
        chk("dv_after_f11", dv_cnt, 9);
        chk("dac16_after_rst", {d16[0], d16[1], d16[2], d16[3]}, B16);
        chk("f12_rx16", r16, RX16C);
        chk("f12_rx24", r24, RX24);
        chk("no_extra_err", fe_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
